// File: rtl/debug_controller.sv
// Debug controller: accepts host debug commands, sequences halt/resume/step
// handshakes with the processor and performs debug register accesses.
module debug_controller #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_data,
  output logic        enter_debug,
  output logic        req_halt,
  output logic        req_resume,
  output logic        step,
  input  logic        halted,
  input  logic        running,
  input  logic        stalled,
  output logic        dm_write,
  output logic [7:0]  dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_access_valid
);

  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT  = CNT_W'(TIMEOUT);
  localparam logic [31:0]      TIMEOUT_DATA = 32'hDEAD_0001;

  localparam logic [2:0] OP_STATUS = 3'd0;
  localparam logic [2:0] OP_HALT   = 3'd1;
  localparam logic [2:0] OP_RESUME = 3'd2;
  localparam logic [2:0] OP_STEP   = 3'd3;
  localparam logic [2:0] OP_READ   = 3'd4;
  localparam logic [2:0] OP_WRITE  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT_WAIT,
    S_RESUME_WAIT,
    S_STEP_RUN,
    S_STEP_HALT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t            state, state_next;
  logic [2:0]        op_q;
  logic [7:0]        addr_q;
  logic [31:0]       wdata_q;
  logic [CNT_W-1:0]  cnt;
  logic              enter_debug_q, enter_debug_next;
  logic              rsp_err_q, rsp_err_next;
  logic [31:0]       rsp_data_q, rsp_data_next;
  logic              accept;
  logic              wait_state;
  logic              timed_out;

  assign accept     = cmd_valid && cmd_ready;
  assign wait_state = (state == S_HALT_WAIT) || (state == S_RESUME_WAIT) ||
                      (state == S_STEP_RUN)  || (state == S_STEP_HALT)   ||
                      (state == S_ACCESS);
  // A timed-out cycle wins over a late completion and drops every request.
  assign timed_out  = wait_state && (cnt == TIMEOUT_CNT);

  // NOTE: every variable gets its default before the case so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next       = state;
    enter_debug_next = enter_debug_q;
    rsp_err_next     = rsp_err_q;
    rsp_data_next    = rsp_data_q;

    if (timed_out) begin
      state_next    = S_RESP;
      rsp_err_next  = 1'b1;
      rsp_data_next = TIMEOUT_DATA;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state_next    = S_RESP;
            rsp_err_next  = 1'b0;
            rsp_data_next = '0;
            case (cmd_op)
              OP_STATUS: rsp_data_next = {29'b0, stalled, running, halted};
              OP_HALT: begin
                enter_debug_next = 1'b1;
                if (!halted) state_next = S_HALT_WAIT;
              end
              OP_RESUME: begin
                if (halted) state_next = S_RESUME_WAIT;
                else        rsp_err_next = 1'b1;
              end
              OP_STEP: begin
                if (halted) state_next = S_STEP_RUN;
                else        rsp_err_next = 1'b1;
              end
              OP_READ, OP_WRITE: begin
                if (halted) state_next = S_ACCESS;
                else        rsp_err_next = 1'b1;
              end
              default: rsp_err_next = 1'b1;
            endcase
          end
        end
        S_HALT_WAIT: begin
          if (halted) state_next = S_RESP;
        end
        S_RESUME_WAIT: begin
          if (running && !halted) begin
            state_next       = S_RESP;
            enter_debug_next = 1'b0;
          end
        end
        S_STEP_RUN: begin
          if (!halted) state_next = S_STEP_HALT;
        end
        S_STEP_HALT: begin
          if (halted) state_next = S_RESP;
        end
        S_ACCESS: begin
          if (dm_access_valid) begin
            state_next = S_RESP;
            if (op_q == OP_READ) rsp_data_next = dm_rdata;
          end
        end
        S_RESP:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      op_q          <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      cnt           <= '0;
      enter_debug_q <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_data_q    <= '0;
    end else begin
      state         <= state_next;
      enter_debug_q <= enter_debug_next;
      rsp_err_q     <= rsp_err_next;
      rsp_data_q    <= rsp_data_next;
      if (accept) begin
        op_q    <= cmd_op;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
      end
      // Counter restarts on every state change so each wait gets a full budget.
      if (state_next != state) cnt <= '0;
      else if (wait_state)     cnt <= cnt + 1'b1;
    end
  end

  // Everything below decodes from state, so reset clears outputs immediately.
  assign cmd_ready   = rst_n && (state == S_IDLE);
  assign rsp_valid   = (state == S_RESP);
  assign rsp_err     = rsp_valid && rsp_err_q;
  assign rsp_data    = rsp_valid ? rsp_data_q : '0;
  assign enter_debug = enter_debug_q;
  assign req_halt    = (state == S_HALT_WAIT)   && !timed_out;
  assign req_resume  = (state == S_RESUME_WAIT) && !timed_out;
  assign step        = (state == S_STEP_RUN) && (cnt == '0) && !timed_out;
  assign dm_addr     = (state == S_ACCESS) ? addr_q : '0;
  assign dm_wdata    = ((state == S_ACCESS) && (op_q == OP_WRITE)) ? wdata_q : '0;
  assign dm_write    = (state == S_ACCESS) && (op_q == OP_WRITE) &&
                       dm_access_valid && !timed_out;

endmodule
